// File: rtl/cvxif_copro_responder.sv
// CV-X-IF coprocessor responder: custom-0 ADD/XOR issued into an in-order pending queue, executed once committed.
// Optional MUL (funct3=2) with registered multiplier is built when CVXIF_RESP_MUL_EN is defined.
module cvxif_copro_responder #(
    parameter int XLEN     = 32,
    parameter int ID_WIDTH = 3,
    parameter int DEPTH    = 4,
    parameter int MUL_LAT  = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [31:0]         issue_instr_i,
    input  logic [XLEN-1:0]     issue_rs1_i,
    input  logic [XLEN-1:0]     issue_rs2_i,
    input  logic [ID_WIDTH-1:0] issue_id_i,
    output logic                issue_accept_o,
    output logic                issue_writeback_o,
    input  logic                commit_valid_i,
    input  logic [ID_WIDTH-1:0] commit_id_i,
    input  logic                commit_kill_i,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [ID_WIDTH-1:0] result_id_o,
    output logic [XLEN-1:0]     result_data_o,
    output logic [4:0]          result_rd_o,
    output logic                result_we_o
);
    // state | meaning
    // IDLE  | waiting for a committed head; silently drops killed heads
    // EXEC  | latency down-counter running on latched operands
    // RESP  | result presented and held until result_ready_i
    localparam int PW = $clog2(DEPTH);
    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;
    typedef enum logic [1:0] {OP_ADD, OP_XOR, OP_MUL} op_e;
    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [4:0]          rd;
        op_e                 op;
        logic [XLEN-1:0]     rs1;
        logic [XLEN-1:0]     rs2;
        logic                committed;
        logic                killed;
    } entry_t;

    entry_t          q [DEPTH];
    logic [PW-1:0]   head, tail;
    logic [PW:0]     count;
    state_e          state;
    logic [CW-1:0]   cnt;
    op_e             op_r;
    logic [XLEN-1:0] a_r, b_r;
`ifdef CVXIF_RESP_MUL_EN
    logic [XLEN-1:0] mul_r;
`endif

    logic dec_ok;
    op_e  dec_op;
    always_comb begin
        dec_ok = 1'b0;
        dec_op = OP_ADD;
        if (issue_instr_i[6:0] == 7'h0B && issue_instr_i[31:25] == 7'd0) begin
            case (issue_instr_i[14:12])
                3'd0: dec_ok = 1'b1;
                3'd1: begin dec_ok = 1'b1; dec_op = OP_XOR; end
`ifdef CVXIF_RESP_MUL_EN
                3'd2: begin dec_ok = 1'b1; dec_op = OP_MUL; end
`endif
                default: dec_ok = 1'b0;
            endcase
        end
    end

    // register-source fields are not needed: operands arrive on issue_rs*_i
    logic unused_instr_bits;
    assign unused_instr_bits = ^issue_instr_i[24:15];

    logic push, pop, bypass, head_live;
    assign issue_ready_o     = !rst_i && (count != (PW+1)'(DEPTH));
    assign issue_accept_o    = !rst_i && dec_ok;
    assign issue_writeback_o = issue_accept_o;
    assign push      = issue_valid_i && issue_ready_o && dec_ok;
    assign bypass    = commit_valid_i && (commit_id_i == issue_id_i);
    assign head_live = (count != '0);
    assign pop = (state == S_IDLE && head_live && q[head].killed) ||
                 (state == S_RESP && result_ready_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= S_IDLE;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            cnt            <= '0;
            op_r           <= OP_ADD;
            a_r            <= '0;
            b_r            <= '0;
`ifdef CVXIF_RESP_MUL_EN
            mul_r          <= '0;
`endif
            result_valid_o <= 1'b0;
            result_id_o    <= '0;
            result_data_o  <= '0;
            result_rd_o    <= '0;
            result_we_o    <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (commit_valid_i && ({1'b0, PW'(i) - head} < count) && q[i].id == commit_id_i) begin
                    if (commit_kill_i) q[i].killed <= 1'b1;
                    else               q[i].committed <= 1'b1;
                end
            end
            // the tail slot is never a live entry when pushing, so this cannot collide with the marking above
            if (push) begin
                q[tail] <= '{id: issue_id_i, rd: issue_instr_i[11:7], op: dec_op,
                             rs1: issue_rs1_i, rs2: issue_rs2_i,
                             committed: bypass && !commit_kill_i, killed: bypass && commit_kill_i};
                tail <= tail + 1'b1;
            end
            if (pop) head <= head + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;

            case (state)
                S_IDLE: begin
                    if (head_live && q[head].committed && !q[head].killed) begin
                        op_r        <= q[head].op;
                        a_r         <= q[head].rs1;
                        b_r         <= q[head].rs2;
                        result_id_o <= q[head].id;
                        result_rd_o <= q[head].rd;
                        cnt         <= (q[head].op == OP_MUL) ? CW'(MUL_LAT - 1) : '0;
`ifdef CVXIF_RESP_MUL_EN
                        mul_r       <= q[head].rs1 * q[head].rs2;
`endif
                        state       <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (cnt == '0) begin
                        case (op_r)
                            OP_XOR:  result_data_o <= a_r ^ b_r;
`ifdef CVXIF_RESP_MUL_EN
                            OP_MUL:  result_data_o <= mul_r;
`endif
                            default: result_data_o <= a_r + b_r;
                        endcase
                        result_valid_o <= 1'b1;
                        result_we_o    <= 1'b1;
                        state          <= S_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (result_ready_i) begin
                        result_valid_o <= 1'b0;
                        result_we_o    <= 1'b0;
                        state          <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cvxif_copro_responder.sv
// Self-checking bench for cvxif_copro_responder: directed scenarios plus randomized traffic against a queue model.
module tb_cvxif_copro_responder;
    localparam int XLEN = 32, IDW = 3, DEPTH = 4, MUL_LAT = 3;
`ifdef CVXIF_RESP_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            issue_valid = 1'b0, issue_ready, issue_accept, issue_writeback;
    logic [31:0]     issue_instr = '0;
    logic [XLEN-1:0] issue_rs1 = '0, issue_rs2 = '0;
    logic [IDW-1:0]  issue_id = '0;
    logic            commit_valid = 1'b0, commit_kill = 1'b0;
    logic [IDW-1:0]  commit_id = '0;
    logic            result_valid, result_ready = 1'b0, result_we;
    logic [IDW-1:0]  result_id;
    logic [XLEN-1:0] result_data;
    logic [4:0]      result_rd;

    int total = 0, bad = 0;

    always #5 clk = ~clk;

    cvxif_copro_responder #(.XLEN(XLEN), .ID_WIDTH(IDW), .DEPTH(DEPTH), .MUL_LAT(MUL_LAT)) dut (
        .clk_i(clk), .rst_i(rst),
        .issue_valid_i(issue_valid), .issue_ready_o(issue_ready), .issue_instr_i(issue_instr),
        .issue_rs1_i(issue_rs1), .issue_rs2_i(issue_rs2), .issue_id_i(issue_id),
        .issue_accept_o(issue_accept), .issue_writeback_o(issue_writeback),
        .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
        .result_valid_o(result_valid), .result_ready_i(result_ready), .result_id_o(result_id),
        .result_data_o(result_data), .result_rd_o(result_rd), .result_we_o(result_we)
    );

    typedef struct {
        logic [IDW-1:0]  id;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        bit              committed;
        bit              killed;
    } ment_t;
    ment_t mq[$];

    function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [2:0] f3,
                                             input logic [4:0] rd, input logic [6:0] opc);
        return {f7, 10'($urandom), f3, rd, opc};
    endfunction

    function automatic bit ref_accept(input logic [31:0] ins);
        return ins[6:0] == 7'h0B && ins[31:25] == 7'd0 &&
               (ins[14:12] == 3'd0 || ins[14:12] == 3'd1 || (MUL_EN && ins[14:12] == 3'd2));
    endfunction

    function automatic logic [XLEN-1:0] ref_op(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        case (f3)
            3'd0:    return a + b;
            3'd1:    return a ^ b;
            default: return a * b;
        endcase
    endfunction

    task automatic idle_inputs();
        issue_valid = 1'b0; commit_valid = 1'b0; commit_kill = 1'b0; result_ready = 1'b0;
    endtask

    task automatic issue_drive(input int id, input logic [2:0] f3, input logic [4:0] rd,
                               input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        issue_valid = 1'b1; issue_id = IDW'(id); issue_instr = mk_instr(7'd0, f3, rd, 7'h0B);
        issue_rs1 = a; issue_rs2 = b;
    endtask

    task automatic step();
        @(posedge clk); @(negedge clk);
    endtask

    // returns the number of rising edges until result_valid is seen, or -1 when the bound expires
    task automatic wait_valid(input int bound, output int n);
        n = -1;
        for (int c = 1; c <= bound; c++) begin
            step();
            if (result_valid) begin n = c; return; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        issue_drive(1, 3'd0, 5'd5, 32'd1, 32'd2);
        step(); step();
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", issue_ready); end
        total++; if (issue_accept !== 1'b0) begin bad++; $display("FAIL reset_accept: got %b want 0", issue_accept); end
        total++; if ({result_valid, result_we, result_id, result_rd, result_data} !== '0) begin
            bad++; $display("FAIL reset_result: got v=%b we=%b id=%0d rd=%0d d=%h want all 0",
                            result_valid, result_we, result_id, result_rd, result_data);
        end
        rst = 1'b0; idle_inputs();
        step();
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b want 1", issue_ready); end
    endtask

    task automatic test_basic_add(input string tag);
        int n;
        issue_drive(1, 3'd0, 5'd5, 32'd7, 32'd9);
        #1;
        total++; if (issue_accept !== 1'b1 || issue_writeback !== 1'b1) begin
            bad++; $display("FAIL %s_accept: got acc=%b wb=%b want 1/1", tag, issue_accept, issue_writeback);
        end
        step();
        issue_valid = 1'b0; commit_valid = 1'b1; commit_id = 3'd1; commit_kill = 1'b0;
        step();
        commit_valid = 1'b0;
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL %s_early: got valid=%b want 0", tag, result_valid); end
        wait_valid(10, n);
        total++; if (n !== 2) begin bad++; $display("FAIL %s_latency: got %0d want 2", tag, n); end
        total++; if (result_id !== 3'd1 || result_rd !== 5'd5 || result_data !== 32'd16 || result_we !== 1'b1) begin
            bad++; $display("FAIL %s_result: got id=%0d rd=%0d d=%0d we=%b want 1/5/16/1", tag, result_id, result_rd, result_data, result_we);
        end
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        total++; if (result_valid !== 1'b0 || issue_ready !== 1'b1) begin
            bad++; $display("FAIL %s_after: got valid=%b ready=%b want 0/1", tag, result_valid, issue_ready);
        end
    endtask

    task automatic test_kill();
        bit seen = 0;
        issue_drive(2, 3'd1, 5'd3, $urandom, $urandom);
        step();
        issue_valid = 1'b0; commit_valid = 1'b1; commit_id = 3'd2; commit_kill = 1'b1;
        step();
        commit_valid = 1'b0; commit_kill = 1'b0; result_ready = 1'b1;
        repeat (10) begin step(); if (result_valid) seen = 1; end
        result_ready = 1'b0;
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL kill_no_result: got result seen=%b want 0", seen); end
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL kill_ready: got %b want 1", issue_ready); end
    endtask

    task automatic test_reject();
        bit seen = 0;
        issue_drive(3, 3'd3, 5'd4, 32'd1, 32'd1);
        #1;
        total++; if (issue_accept !== 1'b0 || issue_writeback !== 1'b0 || issue_ready !== 1'b1) begin
            bad++; $display("FAIL reject_f3: got acc=%b wb=%b rdy=%b want 0/0/1", issue_accept, issue_writeback, issue_ready);
        end
        step();
        issue_instr = mk_instr(7'd0, 3'd2, 5'd4, 7'h0B);
        #1;
        total++; if (issue_accept !== MUL_EN) begin bad++; $display("FAIL reject_mul: got %b want %b", issue_accept, MUL_EN); end
        issue_instr = mk_instr(7'd1, 3'd0, 5'd4, 7'h0B);
        #1;
        total++; if (issue_accept !== 1'b0) begin bad++; $display("FAIL reject_f7: got %b want 0", issue_accept); end
        issue_instr = mk_instr(7'd0, 3'd0, 5'd4, 7'h2B);
        #1;
        total++; if (issue_accept !== 1'b0) begin bad++; $display("FAIL reject_opcode: got %b want 0", issue_accept); end
        issue_valid = 1'b0; commit_valid = 1'b1; commit_id = 3'd3;
        step();
        commit_valid = 1'b0; result_ready = 1'b1;
        repeat (8) begin step(); if (result_valid) seen = 1; end
        result_ready = 1'b0;
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL reject_no_result: got seen=%b want 0", seen); end
    endtask

    task automatic test_full();
        logic [XLEN-1:0] exp_d [4];
        logic [2:0] f3;
        logic [XLEN-1:0] a, b;
        int n;
        for (int i = 0; i < 4; i++) begin
            f3 = 3'($urandom_range(0, 1)); a = $urandom; b = $urandom;
            exp_d[i] = ref_op(f3, a, b);
            issue_drive(i, f3, 5'(10 + i), a, b);
            #1;
            total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL full_ready_%0d: got %b want 1", i, issue_ready); end
            step();
        end
        issue_valid = 1'b0;
        #1;
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL full_not_ready: got %b want 0", issue_ready); end
        for (int i = 0; i < 4; i++) begin
            commit_valid = 1'b1; commit_id = IDW'(i); commit_kill = 1'b0;
            step();
        end
        commit_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!result_valid) wait_valid(20, n);
            total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL full_timeout_%0d: got no result want id %0d", i, i); end
            if (i == 0) begin
                repeat (5) begin
                    step();
                    total++; if (result_valid !== 1'b1 || result_id !== 3'd0 || result_data !== exp_d[0]) begin
                        bad++; $display("FAIL full_hold: got v=%b id=%0d d=%h want 1/0/%h", result_valid, result_id, result_data, exp_d[0]);
                    end
                end
            end
            total++; if (result_id !== IDW'(i) || result_rd !== 5'(10 + i) || result_data !== exp_d[i]) begin
                bad++; $display("FAIL full_order_%0d: got id=%0d rd=%0d d=%h want %0d/%0d/%h",
                                i, result_id, result_rd, result_data, i, 10 + i, exp_d[i]);
            end
            result_ready = 1'b1;
            step();
            result_ready = 1'b0;
        end
        total++; if (result_valid !== 1'b0 || issue_ready !== 1'b1) begin
            bad++; $display("FAIL full_drained: got v=%b rdy=%b want 0/1", result_valid, issue_ready);
        end
    endtask

    task automatic bypass_case(input string tag, input int id, input logic [2:0] f3,
                               input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input int lat);
        int n;
        issue_drive(id, f3, 5'd7, a, b);
        commit_valid = 1'b1; commit_id = IDW'(id); commit_kill = 1'b0;
        step();
        idle_inputs();
        wait_valid(20, n);
        total++; if (n !== lat + 1) begin bad++; $display("FAIL %s_latency: got %0d want %0d", tag, n, lat + 1); end
        total++; if (result_data !== ref_op(f3, a, b) || result_id !== IDW'(id)) begin
            bad++; $display("FAIL %s_data: got id=%0d d=%h want %0d/%h", tag, result_id, result_data, id, ref_op(f3, a, b));
        end
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
    endtask

    task automatic test_bypass();
        bypass_case("bypass_add_wrap", 6, 3'd0, 32'hFFFF_FFFF, 32'd1, 1);
`ifdef CVXIF_RESP_MUL_EN
        bypass_case("bypass_mul_wrap", 5, 3'd2, 32'h0001_0000, 32'h0001_0000, MUL_LAT);
        bypass_case("bypass_mul", 4, 3'd2, 32'd123, 32'd456, MUL_LAT);
`endif
    endtask

    task automatic test_reset_mid();
        int n;
        bit seen = 0;
        for (int i = 0; i < 4; i++) begin
            issue_drive(i, 3'd0, 5'(i), $urandom, $urandom);
            step();
        end
        issue_valid = 1'b0; commit_valid = 1'b1; commit_id = 3'd0;
        step();
        commit_valid = 1'b0;
        wait_valid(10, n);
        total++; if (n < 0) begin bad++; $display("FAIL rstmid_resp: got timeout want a result"); end
        rst = 1'b1;
        issue_drive(1, 3'd0, 5'd5, 32'd1, 32'd1);
        step();
        total++; if ({issue_ready, issue_accept, result_valid, result_we, result_id, result_rd, result_data} !== '0) begin
            bad++; $display("FAIL rstmid_outputs: got rdy=%b acc=%b v=%b we=%b id=%0d rd=%0d d=%h want all 0",
                            issue_ready, issue_accept, result_valid, result_we, result_id, result_rd, result_data);
        end
        rst = 1'b0; idle_inputs();
        step();
        for (int i = 1; i < 4; i++) begin
            commit_valid = 1'b1; commit_id = IDW'(i);
            step();
        end
        commit_valid = 1'b0; result_ready = 1'b1;
        repeat (8) begin step(); if (result_valid) seen = 1; end
        result_ready = 1'b0;
        total++; if (seen !== 1'b0 || issue_ready !== 1'b1) begin
            bad++; $display("FAIL rstmid_empty: got seen=%b rdy=%b want 0/1", seen, issue_ready);
        end
        test_basic_add("post_reset");
    endtask

    task automatic test_random();
        bit busy [8];
        int free_ids[$], cand[$];
        int k, kind, live;
        bit drain, exp_acc, fire_i, fire_r, byp;
        logic [2:0] f3;
        logic [4:0] rd;
        logic [XLEN-1:0] a, b;
        mq.delete();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            drain = (cyc >= 700);
            live = 0;
            foreach (busy[i]) busy[i] = 0;
            foreach (mq[i]) if (!mq[i].killed) begin busy[mq[i].id] = 1; live++; end
            if (drain && live == 0) break;
            free_ids.delete(); cand.delete();
            for (int i = 0; i < 8; i++) if (!busy[i]) free_ids.push_back(i);
            foreach (mq[i]) if (!mq[i].committed && !mq[i].killed) cand.push_back(i);

            issue_valid = !drain && free_ids.size() > 0 && $urandom_range(0, 2) != 0;
            issue_id = free_ids.size() > 0 ? IDW'(free_ids[$urandom_range(0, free_ids.size() - 1)]) : '0;
            kind = $urandom_range(0, 9);
            f3 = kind < 4 ? 3'd0 : kind < 7 ? 3'd1 : kind == 7 ? 3'd2 : 3'($urandom_range(3, 7));
            rd = 5'($urandom);
            a = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom;
            b = $urandom;
            issue_instr = (kind == 9) ? mk_instr(7'($urandom_range(1, 127)), 3'd0, rd, 7'h0B)
                                      : mk_instr(7'd0, f3, rd, 7'h0B);
            issue_rs1 = a; issue_rs2 = b;

            commit_valid = 1'b0; commit_kill = 1'b0; commit_id = '0;
            k = $urandom_range(0, 3);
            if (!drain && k == 0 && issue_valid) begin
                commit_valid = 1'b1; commit_id = issue_id;
            end else if ((drain || k != 3) && cand.size() > 0) begin
                commit_valid = 1'b1; commit_id = mq[cand[$urandom_range(0, cand.size() - 1)]].id;
            end
            if (commit_valid && !drain) commit_kill = ($urandom_range(0, 3) == 0);
            result_ready = drain ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            exp_acc = ref_accept(issue_instr);
            if (issue_valid) begin
                total++; if (issue_accept !== exp_acc || issue_writeback !== exp_acc) begin
                    bad++; $display("FAIL rand_accept: got acc=%b wb=%b want %b (instr %h)", issue_accept, issue_writeback, exp_acc, issue_instr);
                end
            end
            fire_i = issue_valid && issue_ready;
            fire_r = result_valid && result_ready;
            if (fire_r) begin
                k = -1;
                foreach (mq[i]) if (k < 0 && !mq[i].killed) k = i;
                total++;
                if (k < 0) begin
                    bad++; $display("FAIL rand_result: got id=%0d d=%h want no result", result_id, result_data);
                end else begin
                    if (!mq[k].committed || result_id !== mq[k].id || result_rd !== mq[k].rd ||
                        result_data !== mq[k].data || result_we !== 1'b1) begin
                        bad++; $display("FAIL rand_result: got id=%0d rd=%0d d=%h we=%b want id=%0d rd=%0d d=%h we=1 committed=%b",
                                        result_id, result_rd, result_data, result_we, mq[k].id, mq[k].rd, mq[k].data, mq[k].committed);
                    end
                    for (int j = 0; j <= k; j++) void'(mq.pop_front());
                end
            end
            if (commit_valid) begin
                foreach (mq[i]) if (mq[i].id == commit_id) begin
                    if (commit_kill) mq[i].killed = 1; else mq[i].committed = 1;
                end
            end
            if (fire_i && exp_acc) begin
                byp = commit_valid && commit_id == issue_id;
                mq.push_back('{id: issue_id, rd: rd, data: ref_op(f3, a, b),
                               committed: byp && !commit_kill, killed: byp && commit_kill});
            end
            @(negedge clk);
        end
        idle_inputs();
        live = 0;
        foreach (mq[i]) if (!mq[i].killed) live++;
        total++; if (live != 0) begin bad++; $display("FAIL rand_drain: got %0d results outstanding want 0", live); end
        repeat (4) step();
        total++; if (issue_ready !== 1'b1 || result_valid !== 1'b0) begin
            bad++; $display("FAIL rand_final: got rdy=%b v=%b want 1/0", issue_ready, result_valid);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_add("basic_add");
        test_kill();
        test_reject();
        test_full();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
